// File: rtl/piso_serializer_if.sv
// Handshake and serial-output bundle for piso_serializer.
// The master side supplies parallel words; the slave side is the serializer.
interface piso_serializer_if #(
    parameter int WIDTH = 4
) ();
    logic [WIDTH-1:0] d;
    logic             load_valid;
    logic             load_ready;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    modport master (
        output d, load_valid,
        input  load_ready, sout, sout_valid, busy, done
    );

    modport slave (
        input  d, load_valid,
        output load_ready, sout, sout_valid, busy, done
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with valid/ready load and a one-cycle done pulse.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    piso_serializer_if.slave  bus
);
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1
    } state_t;
`endif

    state_t           state_r, next_state_s;
    logic [WIDTH-1:0] word_r, word_next_s;
    logic [CW-1:0]    cnt_r, cnt_next_s;
    logic             sout_r, sout_next_s;
    logic             sout_valid_r, sout_valid_next_s;
    logic             done_r, done_next_s;

    // Frame-relative bit index mapped onto the word according to shift order.
    function automatic logic pick_bit(input logic [WIDTH-1:0] w, input int idx);
        int   sel;
        logic b;
        sel = (MSB_FIRST != 0) ? (WIDTH - 1 - idx) : idx;
        b   = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == sel) begin
                b = w[i];
            end
        end
        return b;
    endfunction

`ifdef PISO_PARITY_EN
    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction
`endif

    // Next-state and next-output decode; registered outputs default to idle.
    always_comb begin
        next_state_s      = state_r;
        word_next_s       = word_r;
        cnt_next_s        = cnt_r;
        sout_next_s       = 1'b0;
        sout_valid_next_s = 1'b0;
        done_next_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.load_valid) begin
                    word_next_s       = bus.d;
                    sout_next_s       = pick_bit(bus.d, 0);
                    sout_valid_next_s = 1'b1;
                    cnt_next_s        = CNT_ONE;
                    next_state_s      = ST_SHIFT;
                end else begin
                    cnt_next_s        = CNT_ZERO;
                end
            end
            ST_SHIFT: begin
                if (cnt_r < CNT_LAST) begin
                    sout_next_s       = pick_bit(word_r, int'(cnt_r));
                    sout_valid_next_s = 1'b1;
                    cnt_next_s        = cnt_r + CNT_ONE;
                end else begin
`ifdef PISO_PARITY_EN
                    sout_next_s       = even_parity(word_r);
                    sout_valid_next_s = 1'b1;
                    next_state_s      = ST_PARITY;
`else
                    done_next_s       = 1'b1;
                    cnt_next_s        = CNT_ZERO;
                    next_state_s      = ST_IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                done_next_s  = 1'b1;
                cnt_next_s   = CNT_ZERO;
                next_state_s = ST_IDLE;
            end
`endif
            default: begin
                cnt_next_s   = CNT_ZERO;
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            word_r       <= {WIDTH{1'b0}};
            cnt_r        <= CNT_ZERO;
            sout_r       <= 1'b0;
            sout_valid_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            word_r       <= word_next_s;
            cnt_r        <= cnt_next_s;
            sout_r       <= sout_next_s;
            sout_valid_r <= sout_valid_next_s;
            done_r       <= done_next_s;
        end
    end

    assign bus.load_ready = (state_r == ST_IDLE);
    assign bus.busy       = (state_r != ST_IDLE);
    assign bus.sout       = sout_r;
    assign bus.sout_valid = sout_valid_r;
    assign bus.done       = done_r;
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first instances,
// serial bits checked against a queue filled when each word is loaded.
module tb_piso_serializer;
    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    bit   exp_q_m[$];
    bit   exp_q_l[$];

    piso_serializer_if #(.WIDTH(W)) bus_m ();
    piso_serializer_if #(.WIDTH(W)) bus_l ();

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input bit msb, input logic [W-1:0] w);
        bit b;
        for (int i = 0; i < W; i++) begin
            b = msb ? w[W-1-i] : w[i];
            if (msb) exp_q_m.push_back(b);
            else     exp_q_l.push_back(b);
        end
`ifdef PISO_PARITY_EN
        if (msb) exp_q_m.push_back(^w);
        else     exp_q_l.push_back(^w);
`endif
    endtask

    // Advance one clock and compare any serial bit against the scoreboard.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (bus_m.sout_valid === 1'b1) begin
            if (exp_q_m.size() == 0) chk("msb_unexpected_bit", 1'b1, 1'b0);
            else                     chk("msb_bit", bus_m.sout, exp_q_m.pop_front());
        end
        if (bus_l.sout_valid === 1'b1) begin
            if (exp_q_l.size() == 0) chk("lsb_unexpected_bit", 1'b1, 1'b0);
            else                     chk("lsb_bit", bus_l.sout, exp_q_l.pop_front());
        end
    endtask

    // Load one word into the MSB-first instance and run it to its done pulse.
    task automatic frame_m(input logic [W-1:0] w);
        bus_m.d          = w;
        bus_m.load_valid = 1'b1;
        push_frame(1'b1, w);
        tick();
        bus_m.load_valid = 1'b0;
        chk("msb_busy_after_accept", bus_m.busy, 1'b1);
        chk("msb_ready_after_accept", bus_m.load_ready, 1'b0);
        repeat (FRAME - 1) begin
            tick();
            chk("msb_no_early_done", bus_m.done, 1'b0);
        end
        tick();
        chk("msb_done", bus_m.done, 1'b1);
        chk("msb_ready_at_done", bus_m.load_ready, 1'b1);
        chk("msb_valid_low_at_done", bus_m.sout_valid, 1'b0);
        tick();
        chk("msb_done_one_cycle", bus_m.done, 1'b0);
        chk("msb_queue_drained", (exp_q_m.size() == 0), 1'b1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus_m.d = 4'b0000; bus_m.load_valid = 1'b0;
        bus_l.d = 4'b0000; bus_l.load_valid = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_sout", bus_m.sout, 1'b0);
        chk("rst_sout_valid", bus_m.sout_valid, 1'b0);
        chk("rst_done", bus_m.done, 1'b0);
        chk("rst_load_ready", bus_m.load_ready, 1'b1);
        chk("rst_busy", bus_m.busy, 1'b0);
        chk("rst_lsb_ready", bus_l.load_ready, 1'b1);
        rst = 1'b0;
        tick();

        // MSB-first frame 1010
        frame_m(4'b1010);

        // LSB-first frame 1100 -> 0,0,1,1
        bus_l.d          = 4'b1100;
        bus_l.load_valid = 1'b1;
        push_frame(1'b0, 4'b1100);
        tick();
        bus_l.load_valid = 1'b0;
        chk("lsb_busy", bus_l.busy, 1'b1);
        repeat (FRAME - 1) tick();
        tick();
        chk("lsb_done", bus_l.done, 1'b1);
        tick();
        chk("lsb_done_one_cycle", bus_l.done, 1'b0);
        chk("lsb_queue_drained", (exp_q_l.size() == 0), 1'b1);

        // Load while busy is ignored; held word accepted on the done cycle
        bus_m.d          = 4'b1111;
        bus_m.load_valid = 1'b1;
        push_frame(1'b1, 4'b1111);
        tick();
        bus_m.d = 4'b0000;
        repeat (FRAME - 1) begin
            tick();
            chk("busy_ready_low", bus_m.load_ready, 1'b0);
        end
        chk("first_frame_drained", (exp_q_m.size() == 0), 1'b1);
        push_frame(1'b1, 4'b0000);
        tick();
        chk("b2b_done", bus_m.done, 1'b1);
        chk("b2b_ready", bus_m.load_ready, 1'b1);
        tick();
        bus_m.load_valid = 1'b0;
        chk("b2b_second_accepted", bus_m.sout_valid, 1'b1);
        chk("b2b_done_cleared", bus_m.done, 1'b0);
        repeat (FRAME - 1) tick();
        tick();
        chk("b2b_second_done", bus_m.done, 1'b1);
        tick();
        chk("b2b_queue_drained", (exp_q_m.size() == 0), 1'b1);

        // Reset mid-frame aborts with no done pulse
        bus_m.d          = 4'b1010;
        bus_m.load_valid = 1'b1;
        exp_q_m.push_back(1'b1);
        exp_q_m.push_back(1'b0);
        tick();
        bus_m.load_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", bus_m.sout_valid, 1'b0);
        chk("abort_ready", bus_m.load_ready, 1'b1);
        chk("abort_busy", bus_m.busy, 1'b0);
        repeat (FRAME + 2) begin
            tick();
            chk("abort_no_done", bus_m.done, 1'b0);
        end
        chk("abort_queue_drained", (exp_q_m.size() == 0), 1'b1);

        // Parity-sensitive words (parity bits appended when enabled)
        frame_m(4'b1011);
        frame_m(4'b1100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
